// File: rtl/cpu_dbg_pkg.sv
// Shared debug definitions for the CPU register file and its dump reader.
package cpu_dbg_pkg;

    localparam int unsigned DefNumRegs = 32;
    localparam int unsigned DefAddrW   = 5;
    localparam int unsigned DefDataW   = 32;

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StEmitA,
        StEmitB,
        StFinish
    } dump_state_e;

    typedef struct packed {
        logic [DefAddrW-1:0] index;
        logic [DefDataW-1:0] data;
    } dump_entry_t;

endpackage

// File: rtl/regfile_dump_reader.sv
// Walks the register file two registers per pass and streams (index, value) entries over
// valid/ready. Define REGFILE_DUMP_NONZERO_EN to skip entries whose value is zero.
module regfile_dump_reader
    import cpu_dbg_pkg::*;
#(
    parameter int unsigned NUM_REGS = DefNumRegs,
    parameter int unsigned ADDR_W   = DefAddrW,
    parameter int unsigned DATA_W   = DefDataW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    output logic [ADDR_W-1:0] ReadRegister1,
    output logic [ADDR_W-1:0] ReadRegister2,
    input  logic [DATA_W-1:0] ReadData1,
    input  logic [DATA_W-1:0] ReadData2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_index,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              done
);

`ifdef REGFILE_DUMP_NONZERO_EN
    localparam bit SkipZero = 1'b1;
`else
    localparam bit SkipZero = 1'b0;
`endif

    localparam logic [ADDR_W-1:0] LastPair = ADDR_W'(NUM_REGS / 2 - 1);

    dump_state_e       state_q, state_d;
    logic [ADDR_W-1:0] p_q, p_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [ADDR_W-1:0] rr1_q, rr1_d;
    logic [ADDR_W-1:0] rr2_q, rr2_d;
    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] index_q, index_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              advance;
    logic [ADDR_W-1:0] even_idx;
    logic [ADDR_W-1:0] odd_idx;

    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        a_d     = a_q;
        b_d     = b_q;
        rr1_d   = rr1_q;
        rr2_d   = rr2_q;
        valid_d = 1'b0;
        index_d = index_q;
        data_d  = data_q;

        // A skipped (invalid) entry advances without waiting for a handshake.
        advance = !valid_q || out_ready;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRead;
                    p_d     = '0;
                end
            end
            StRead: begin
                a_d     = ReadData1;
                b_d     = ReadData2;
                state_d = StEmitA;
            end
            StEmitA: begin
                if (advance) begin
                    state_d = StEmitB;
                end
            end
            StEmitB: begin
                if (advance) begin
                    if (p_q == LastPair) begin
                        state_d = StFinish;
                        p_d     = '0;
                    end else begin
                        state_d = StRead;
                        p_d     = p_q + ADDR_W'(1);
                    end
                end
            end
            StFinish: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // FINISH already ends the dump, so abort there does not stretch done.
        if (abort && state_q != StIdle && state_q != StFinish) begin
            state_d = StFinish;
            p_d     = '0;
        end

        even_idx = p_d << 1;
        odd_idx  = even_idx | ADDR_W'(1);

        // Outputs are registered, so they are decoded from the state being entered.
        case (state_d)
            StRead: begin
                rr1_d = even_idx;
                rr2_d = odd_idx;
            end
            StEmitA: begin
                valid_d = !SkipZero || (a_d != '0);
                index_d = even_idx;
                data_d  = a_d;
            end
            StEmitB: begin
                valid_d = !SkipZero || (b_d != '0);
                index_d = odd_idx;
                data_d  = b_d;
            end
            default: ;
        endcase

        busy_d = (state_d == StRead) || (state_d == StEmitA) || (state_d == StEmitB);
        done_d = (state_d == StFinish);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            p_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            rr1_q   <= '0;
            rr2_q   <= '0;
            valid_q <= 1'b0;
            index_q <= '0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            a_q     <= a_d;
            b_q     <= b_d;
            rr1_q   <= rr1_d;
            rr2_q   <= rr2_d;
            valid_q <= valid_d;
            index_q <= index_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign ReadRegister1 = rr1_q;
    assign ReadRegister2 = rr2_q;
    assign out_valid     = valid_q;
    assign out_index     = index_q;
    assign out_data      = data_q;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Self-checking bench for regfile_dump_reader with a behavioural register file and dump model.
module tb_regfile_dump_reader;
    import cpu_dbg_pkg::*;

    localparam int NR = DefNumRegs;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic out_ready = 1'b0;
    logic [DefAddrW-1:0] rr1, rr2, out_index;
    logic [DefDataW-1:0] rd1, rd2, out_data;
    logic out_valid, busy, done;

    logic [DefDataW-1:0] regs [NR];

    int n_checks = 0;
    int n_fail = 0;

    dump_entry_t got_q[$];
    dump_entry_t exp_q[$];
    int rise_q[$];
    int done_cyc, done_cnt, first_valid_cyc, stall_err, abort_cyc;
    int post_abort_valid, post_rst_bad, valid_after_rst;
    logic busy_end;

    always #5 clk = ~clk;

    assign rd1 = regs[rr1];
    assign rd2 = regs[rr2];

    regfile_dump_reader dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .abort        (abort),
        .ReadRegister1(rr1),
        .ReadRegister2(rr2),
        .ReadData1    (rd1),
        .ReadData2    (rd2),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_index    (out_index),
        .out_data     (out_data),
        .busy         (busy),
        .done         (done)
    );

    // Reference: every register in index order, zero values dropped when the filter is built in.
    function automatic void build_exp();
        exp_q.delete();
        for (int i = 0; i < NR; i++) begin
`ifdef REGFILE_DUMP_NONZERO_EN
            if (regs[i] == '0) continue;
`endif
            exp_q.push_back('{index: DefAddrW'(i), data: regs[i]});
        end
    endfunction

    // With ready high, each pair costs READ + two emit cycles after the start cycle.
    function automatic int exp_cycle(input int idx);
        return 2 + 3 * (idx / 2) + (idx % 2);
    endfunction

    function automatic int count_below(input int idx);
        int n = 0;
        foreach (exp_q[i]) if (int'(exp_q[i].index) < idx) n++;
        return n;
    endfunction

    task automatic run_dump(input int ready_mode, input int abort_idx, input int rst_idx,
                            input bit hold_start);
        int end_cyc = 1000;
        bit inj_abort = 0, inj_rst = 0, abort_done = 0, rst_done = 0, prev_stall = 0;
        logic prev_busy;
        logic [DefAddrW-1:0] prev_idx = '0;
        logic [DefDataW-1:0] prev_data = '0;
        got_q.delete();
        rise_q.delete();
        done_cyc = -1; done_cnt = 0; first_valid_cyc = -1; stall_err = 0; abort_cyc = -1;
        post_abort_valid = 0; post_rst_bad = 0; valid_after_rst = 0;
        prev_busy = busy;
        @(posedge clk); #1 start = 1'b1;
        for (int c = 1; c <= end_cyc; c++) begin
            @(posedge clk); #1;
            if (!hold_start) start = 1'b0;
            if (inj_abort) begin
                inj_abort = 0;
                abort = 1'b0;
                if (out_valid) post_abort_valid++;
            end
            if (inj_rst) begin
                inj_rst = 0;
                rst_n = 1'b1;
                if (out_valid || busy || done || out_index != '0 || out_data != '0 ||
                    rr1 != '0 || rr2 != '0) post_rst_bad++;
            end else if (rst_done && out_valid) begin
                valid_after_rst++;
            end
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc = c;
                    if (c + 3 < end_cyc) end_cyc = c + 3;
                end
            end
            if (busy && !prev_busy) rise_q.push_back(c);
            prev_busy = busy;
            if (out_valid && first_valid_cyc < 0) first_valid_cyc = c;
            if (prev_stall && (!out_valid || out_index !== prev_idx || out_data !== prev_data))
                stall_err++;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (c % 3 == 2);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (abort_idx >= 0 && !abort_done && out_valid &&
                out_index == DefAddrW'(abort_idx)) begin
                abort = 1'b1; inj_abort = 1; abort_done = 1; abort_cyc = c;
            end
            if (rst_idx >= 0 && !rst_done && out_valid && out_index == DefAddrW'(rst_idx)) begin
                rst_n = 1'b0; inj_rst = 1; rst_done = 1; end_cyc = c + 10;
            end
            if (out_valid && out_ready && !inj_abort && !inj_rst)
                got_q.push_back('{index: out_index, data: out_data});
            prev_stall = out_valid && !out_ready && !inj_abort && !inj_rst;
            prev_idx = out_index;
            prev_data = out_data;
        end
        busy_end = busy;
        out_ready = 1'b0;
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        n_checks++; if (out_index !== '0) begin n_fail++; $display("FAIL reset_index: got %0d want 0", out_index); end
        n_checks++; if (out_data !== '0) begin n_fail++; $display("FAIL reset_data: got %0h want 0", out_data); end
        n_checks++; if (rr1 !== '0) begin n_fail++; $display("FAIL reset_rr1: got %0d want 0", rr1); end
        n_checks++; if (rr2 !== '0) begin n_fail++; $display("FAIL reset_rr2: got %0d want 0", rr2); end
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b want 0", busy); end
    endtask

    task automatic check_sequence(input string name);
        n_checks++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL %s_count: got %0d entries want %0d", name, got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL %s_entry%0d: got idx %0d data %0h want idx %0d data %0h", name, i,
                         got_q[i].index, got_q[i].data, exp_q[i].index, exp_q[i].data);
            end
        end
    endtask

    task automatic test_full_dump();
        for (int i = 0; i < NR; i++) regs[i] = DefDataW'(i * 3);
        build_exp();
        run_dump(0, -1, -1, 1'b0);
        check_sequence("full");
        n_checks++; if (done_cyc != 1 + 3 * NR / 2) begin n_fail++; $display("FAIL full_done_cycle: got %0d want %0d", done_cyc, 1 + 3 * NR / 2); end
        n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL full_done_pulses: got %0d want 1", done_cnt); end
        if (exp_q.size() > 0) begin
            n_checks++;
            if (first_valid_cyc != exp_cycle(int'(exp_q[0].index))) begin
                n_fail++;
                $display("FAIL full_first_valid: got %0d want %0d", first_valid_cyc, exp_cycle(int'(exp_q[0].index)));
            end
        end
        n_checks++; if (busy_end !== 1'b0) begin n_fail++; $display("FAIL full_busy_after: got %b want 0", busy_end); end
    endtask

    task automatic test_stall();
        for (int i = 0; i < NR; i++) regs[i] = DefDataW'(i * 3);
        build_exp();
        run_dump(1, -1, -1, 1'b0);
        check_sequence("stall");
        n_checks++; if (stall_err != 0) begin n_fail++; $display("FAIL stall_stable: got %0d unstable cycles want 0", stall_err); end
        n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL stall_done_pulses: got %0d want 1", done_cnt); end
    endtask

    task automatic test_random();
        for (int i = 0; i < NR; i++) regs[i] = ($urandom_range(0, 3) == 0) ? '0 : $urandom;
        build_exp();
        run_dump(2, -1, -1, 1'b0);
        check_sequence("random");
        n_checks++; if (stall_err != 0) begin n_fail++; $display("FAIL random_stable: got %0d unstable cycles want 0", stall_err); end
        n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL random_done_pulses: got %0d want 1", done_cnt); end
    endtask

    task automatic test_abort();
        int n_keep;
        for (int i = 0; i < NR; i++) regs[i] = DefDataW'(i * 3);
        build_exp();
        n_keep = count_below(11);
        run_dump(0, 11, -1, 1'b0);
        n_checks++; if (got_q.size() != n_keep) begin n_fail++; $display("FAIL abort_count: got %0d entries want %0d", got_q.size(), n_keep); end
        for (int i = 0; i < got_q.size() && i < n_keep; i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL abort_entry%0d: got idx %0d want idx %0d", i, got_q[i].index, exp_q[i].index);
            end
        end
        n_checks++; if (post_abort_valid != 0) begin n_fail++; $display("FAIL abort_valid_drop: got %0d want 0", post_abort_valid); end
        n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL abort_done_pulses: got %0d want 1", done_cnt); end
        n_checks++; if (done_cyc != abort_cyc + 1) begin n_fail++; $display("FAIL abort_done_cycle: got %0d want %0d", done_cyc, abort_cyc + 1); end
        n_checks++; if (busy_end !== 1'b0) begin n_fail++; $display("FAIL abort_busy_after: got %b want 0", busy_end); end
        run_dump(0, -1, -1, 1'b0);
        check_sequence("restart");
    endtask

    task automatic test_reset_mid();
        int n_keep;
        for (int i = 0; i < NR; i++) regs[i] = DefDataW'(i * 3 + 1);
        build_exp();
        n_keep = count_below(6);
        run_dump(0, -1, 6, 1'b0);
        n_checks++; if (got_q.size() != n_keep) begin n_fail++; $display("FAIL rstmid_count: got %0d entries want %0d", got_q.size(), n_keep); end
        n_checks++; if (post_rst_bad != 0) begin n_fail++; $display("FAIL rstmid_outputs: got %0d nonzero cycles want 0", post_rst_bad); end
        n_checks++; if (valid_after_rst != 0) begin n_fail++; $display("FAIL rstmid_resume: got %0d valid cycles want 0", valid_after_rst); end
        n_checks++; if (done_cnt != 0) begin n_fail++; $display("FAIL rstmid_done: got %0d pulses want 0", done_cnt); end
        n_checks++; if (busy_end !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", busy_end); end
    endtask

    task automatic test_start_held();
        for (int i = 0; i < NR; i++) regs[i] = DefDataW'(i * 3);
        run_dump(0, -1, -1, 1'b1);
        n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL held_done_pulses: got %0d want 1", done_cnt); end
        n_checks++; if (rise_q.size() != 2) begin n_fail++; $display("FAIL held_dumps: got %0d busy rises want 2", rise_q.size()); end
        if (rise_q.size() == 2) begin
            n_checks++; if (rise_q[0] != 1) begin n_fail++; $display("FAIL held_first_start: got %0d want 1", rise_q[0]); end
            n_checks++; if (rise_q[1] != done_cyc + 2) begin n_fail++; $display("FAIL held_restart: got %0d want %0d", rise_q[1], done_cyc + 2); end
        end
        abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_abort_idle();
        int dones = 0, busies = 0;
        abort = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            if (done) dones++;
            if (busy) busies++;
        end
        abort = 1'b0;
        n_checks++; if (dones != 0) begin n_fail++; $display("FAIL idle_abort_done: got %0d want 0", dones); end
        n_checks++; if (busies != 0) begin n_fail++; $display("FAIL idle_abort_busy: got %0d want 0", busies); end
    endtask

`ifdef REGFILE_DUMP_NONZERO_EN
    task automatic test_nonzero();
        for (int i = 0; i < NR; i++) regs[i] = '0;
        regs[0] = $urandom | 1;
        regs[4] = $urandom | 1;
        regs[7] = $urandom | 1;
        build_exp();
        n_checks++; if (exp_q.size() != 3) begin n_fail++; $display("FAIL nz_model: got %0d want 3", exp_q.size()); end
        run_dump(0, -1, -1, 1'b0);
        check_sequence("nonzero");
        n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL nz_done_pulses: got %0d want 1", done_cnt); end
        for (int i = 0; i < NR; i++) regs[i] = '0;
        build_exp();
        run_dump(2, -1, -1, 1'b0);
        n_checks++; if (got_q.size() != 0) begin n_fail++; $display("FAIL nz_allzero_count: got %0d want 0", got_q.size()); end
        n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL nz_allzero_done: got %0d want 1", done_cnt); end
    endtask
`endif

    initial begin
        for (int i = 0; i < NR; i++) regs[i] = '0;
        test_reset();
        test_full_dump();
        test_stall();
        test_random();
        test_abort();
        test_reset_mid();
        test_start_held();
        test_abort_idle();
`ifdef REGFILE_DUMP_NONZERO_EN
        test_nonzero();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
